// File: rtl/jtag_tap_controller_pkg.sv
// -----------------------------------------------------------------------------
// jtag_tap_controller_pkg
// Shared types and constants for the JTAG TAP controller:
//   - JtagTapStateEnum           : 4-bit encoding of the 16 TAP states
//   - JtagInstructionOpcodeEnum  : recognised instruction opcodes
//   - JtagInstructionWidthEnum / JtagTestVectorWidthEnum : legal widths
//   - DEFAULT_IDCODE             : default IDCODE (bit 0 set as 1149.1 requires)
//   - decode_dr_select()         : maps an opcode to the data register it selects
// -----------------------------------------------------------------------------
package jtag_tap_controller_pkg;

    typedef enum logic [3:0] {
        TAP_TEST_LOGIC_RESET = 4'd0,
        TAP_RUN_TEST_IDLE    = 4'd1,
        TAP_SELECT_DR        = 4'd2,
        TAP_CAPTURE_DR       = 4'd3,
        TAP_SHIFT_DR         = 4'd4,
        TAP_EXIT1_DR         = 4'd5,
        TAP_PAUSE_DR         = 4'd6,
        TAP_EXIT2_DR         = 4'd7,
        TAP_UPDATE_DR        = 4'd8,
        TAP_SELECT_IR        = 4'd9,
        TAP_CAPTURE_IR       = 4'd10,
        TAP_SHIFT_IR         = 4'd11,
        TAP_EXIT1_IR         = 4'd12,
        TAP_PAUSE_IR         = 4'd13,
        TAP_EXIT2_IR         = 4'd14,
        TAP_UPDATE_IR        = 4'd15
    } JtagTapStateEnum;

    typedef enum logic [1:0] {
        OP_BYPASS     = 2'd0,
        OP_IDCODE     = 2'd1,
        OP_TESTVECTOR = 2'd2
    } JtagInstructionOpcodeEnum;

    // Legal parameter values for the controller.
    typedef enum int {
        INSTR_WIDTH_3 = 3,
        INSTR_WIDTH_4 = 4,
        INSTR_WIDTH_5 = 5
    } JtagInstructionWidthEnum;

    typedef enum int {
        TEST_VECTOR_WIDTH_8  = 8,
        TEST_VECTOR_WIDTH_16 = 16,
        TEST_VECTOR_WIDTH_24 = 24,
        TEST_VECTOR_WIDTH_32 = 32
    } JtagTestVectorWidthEnum;

    localparam logic [31:0] DEFAULT_IDCODE = 32'h1234_5677;

    // Which data register sits between tdi and tdo in the DR column.
    typedef enum logic [1:0] {
        DR_SEL_BYPASS     = 2'd0,
        DR_SEL_IDCODE     = 2'd1,
        DR_SEL_TESTVECTOR = 2'd2
    } dr_select_e;

    // Opcode arrives zero-extended to 8 bits so one function serves every
    // legal instruction width. Unknown opcodes fall back to bypass.
    function automatic dr_select_e decode_dr_select(input logic [7:0] opcode);
        dr_select_e sel;
        sel = DR_SEL_BYPASS;
        if (opcode == 8'(OP_IDCODE)) begin
            sel = DR_SEL_IDCODE;
        end else if (opcode == 8'(OP_TESTVECTOR)) begin
            sel = DR_SEL_TESTVECTOR;
        end
        return sel;
    endfunction

endpackage

// File: rtl/jtag_tap_controller_if.sv
// -----------------------------------------------------------------------------
// jtag_tap_controller_if
// Pin-side JTAG signals plus the parallel test-vector ports of the TAP.
//   tms, tdi           : serial control/data from the JTAG master
//   tdo, tdoEnable     : serial data back, enable high in Shift-IR/Shift-DR
//   tapState           : current TAP state (debug/observation)
//   instruction        : active instruction register
//   testVectorIn       : parallel capture value for the test-vector register
//   testVectorOut      : parallel update value from the test-vector register
//   updateValid        : strobe for testVectorOut
// Handshake: updateValid is a one-cycle strobe with no ready/backpressure; the
// consumer must take testVectorOut in the cycle updateValid is high (the value
// then stays stable until the next update or reset).
// Modports: master = JTAG driver / test logic side, slave = the TAP controller.
// -----------------------------------------------------------------------------
interface jtag_tap_controller_if
    import jtag_tap_controller_pkg::*;
#(
    parameter int INSTR_WIDTH       = 5,
    parameter int TEST_VECTOR_WIDTH = 32
) ();

    logic                         tms;
    logic                         tdi;
    logic                         tdo;
    logic                         tdoEnable;
    JtagTapStateEnum              tapState;
    logic [INSTR_WIDTH-1:0]       instruction;
    logic [TEST_VECTOR_WIDTH-1:0] testVectorIn;
    logic [TEST_VECTOR_WIDTH-1:0] testVectorOut;
    logic                         updateValid;

    modport master (
        output tms, tdi, testVectorIn,
        input  tdo, tdoEnable, tapState, instruction, testVectorOut, updateValid
    );

    modport slave (
        input  tms, tdi, testVectorIn,
        output tdo, tdoEnable, tapState, instruction, testVectorOut, updateValid
    );

endinterface

// File: rtl/jtag_tap_controller_fsm.sv
// -----------------------------------------------------------------------------
// jtag_tap_fsm
// 16-state IEEE 1149.1 TAP state machine driven by tms.
//   i_clk   : TCK
//   i_reset : synchronous active-high reset, forces Test-Logic-Reset
//   i_tms   : test mode select
//   o_state : current (registered) TAP state
// -----------------------------------------------------------------------------
module jtag_tap_fsm
    import jtag_tap_controller_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_tms,
    output JtagTapStateEnum o_state
);

    JtagTapStateEnum r_state;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= TAP_TEST_LOGIC_RESET;
        end else begin
            case (r_state)
                TAP_TEST_LOGIC_RESET: r_state <= i_tms ? TAP_TEST_LOGIC_RESET : TAP_RUN_TEST_IDLE;
                TAP_RUN_TEST_IDLE:    r_state <= i_tms ? TAP_SELECT_DR        : TAP_RUN_TEST_IDLE;
                TAP_SELECT_DR:        r_state <= i_tms ? TAP_SELECT_IR        : TAP_CAPTURE_DR;
                TAP_CAPTURE_DR:       r_state <= i_tms ? TAP_EXIT1_DR         : TAP_SHIFT_DR;
                TAP_SHIFT_DR:         r_state <= i_tms ? TAP_EXIT1_DR         : TAP_SHIFT_DR;
                TAP_EXIT1_DR:         r_state <= i_tms ? TAP_UPDATE_DR        : TAP_PAUSE_DR;
                TAP_PAUSE_DR:         r_state <= i_tms ? TAP_EXIT2_DR         : TAP_PAUSE_DR;
                TAP_EXIT2_DR:         r_state <= i_tms ? TAP_UPDATE_DR        : TAP_SHIFT_DR;
                TAP_UPDATE_DR:        r_state <= i_tms ? TAP_SELECT_DR        : TAP_RUN_TEST_IDLE;
                TAP_SELECT_IR:        r_state <= i_tms ? TAP_TEST_LOGIC_RESET : TAP_CAPTURE_IR;
                TAP_CAPTURE_IR:       r_state <= i_tms ? TAP_EXIT1_IR         : TAP_SHIFT_IR;
                TAP_SHIFT_IR:         r_state <= i_tms ? TAP_EXIT1_IR         : TAP_SHIFT_IR;
                TAP_EXIT1_IR:         r_state <= i_tms ? TAP_UPDATE_IR        : TAP_PAUSE_IR;
                TAP_PAUSE_IR:         r_state <= i_tms ? TAP_EXIT2_IR         : TAP_PAUSE_IR;
                TAP_EXIT2_IR:         r_state <= i_tms ? TAP_UPDATE_IR        : TAP_SHIFT_IR;
                TAP_UPDATE_IR:        r_state <= i_tms ? TAP_SELECT_DR        : TAP_RUN_TEST_IDLE;
                default:              r_state <= TAP_TEST_LOGIC_RESET;
            endcase
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/jtag_tap_controller.sv
// -----------------------------------------------------------------------------
// jtag_tap_controller
// IEEE 1149.1-style TAP with bypass, IDCODE and a parallel test-vector register.
//   clk     : TCK, all state changes on the rising edge
//   reset   : synchronous active-high reset
//   io_jtag : slave modport carrying tms/tdi/tdo/tdoEnable, tapState,
//             instruction, testVectorIn/Out and updateValid
// Parameters:
//   INSTR_WIDTH       : 3..5, instruction register width
//   TEST_VECTOR_WIDTH : 8/16/24/32, test-vector register width
//   IDCODE_VALUE      : value captured for IDCODE scans (bit 0 must be 1)
// -----------------------------------------------------------------------------
module jtag_tap_controller
    import jtag_tap_controller_pkg::*;
#(
    parameter int          INSTR_WIDTH       = 5,
    parameter int          TEST_VECTOR_WIDTH = 32,
    parameter logic [31:0] IDCODE_VALUE      = DEFAULT_IDCODE
) (
    input  logic                         clk,
    input  logic                         reset,
    jtag_tap_controller_if.slave         io_jtag
);

    localparam logic [INSTR_WIDTH-1:0] OPC_IDCODE = INSTR_WIDTH'(OP_IDCODE);
    // Capture pattern required by 1149.1: two LSBs are 01.
    localparam logic [INSTR_WIDTH-1:0] IR_CAPTURE = {{(INSTR_WIDTH-2){1'b0}}, 2'b01};

    JtagTapStateEnum                w_state;
    dr_select_e                     w_dr_sel;
    logic                           w_enter_tlr;
    logic                           w_enter_update_dr;
    logic                           w_tdo;

    logic [INSTR_WIDTH-1:0]         r_instruction;
    logic [INSTR_WIDTH-1:0]         r_ir_shift;
    logic                           r_bypass;
    logic [31:0]                    r_idcode_shift;
    logic [TEST_VECTOR_WIDTH-1:0]   r_tv_shift;
    logic [TEST_VECTOR_WIDTH-1:0]   r_tv_out;
    logic                           r_update_valid;

    jtag_tap_fsm u_fsm (
        .i_clk   (clk),
        .i_reset (reset),
        .i_tms   (io_jtag.tms),
        .o_state (w_state)
    );

    assign w_dr_sel = decode_dr_select({{(8-INSTR_WIDTH){1'b0}}, r_instruction});

    // The two transitions whose side effects must be visible in the target
    // state's own cycle are decoded here from the current state and tms, so
    // the registers load on the same edge the FSM moves.
    assign w_enter_tlr       = io_jtag.tms &&
                               ((w_state == TAP_TEST_LOGIC_RESET) || (w_state == TAP_SELECT_IR));
    assign w_enter_update_dr = io_jtag.tms &&
                               ((w_state == TAP_EXIT1_DR) || (w_state == TAP_EXIT2_DR));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instruction  <= OPC_IDCODE;
            r_ir_shift     <= '0;
            r_bypass       <= 1'b0;
            r_idcode_shift <= '0;
            r_tv_shift     <= '0;
            r_tv_out       <= '0;
            r_update_valid <= 1'b0;
        end else begin
            r_update_valid <= 1'b0;

            case (w_state)
                TAP_CAPTURE_IR: r_ir_shift    <= IR_CAPTURE;
                TAP_SHIFT_IR:   r_ir_shift    <= {io_jtag.tdi, r_ir_shift[INSTR_WIDTH-1:1]};
                TAP_UPDATE_IR:  r_instruction <= r_ir_shift;
                TAP_CAPTURE_DR: begin
                    case (w_dr_sel)
                        DR_SEL_IDCODE:     r_idcode_shift <= IDCODE_VALUE;
                        DR_SEL_TESTVECTOR: r_tv_shift     <= io_jtag.testVectorIn;
                        default:           r_bypass       <= 1'b0;
                    endcase
                end
                TAP_SHIFT_DR: begin
                    case (w_dr_sel)
                        DR_SEL_IDCODE:     r_idcode_shift <= {io_jtag.tdi, r_idcode_shift[31:1]};
                        DR_SEL_TESTVECTOR: r_tv_shift     <= {io_jtag.tdi, r_tv_shift[TEST_VECTOR_WIDTH-1:1]};
                        default:           r_bypass       <= io_jtag.tdi;
                    endcase
                end
                default: ;
            endcase

            if (w_enter_update_dr && (w_dr_sel == DR_SEL_TESTVECTOR)) begin
                r_tv_out       <= r_tv_shift;
                r_update_valid <= 1'b1;
            end

            if (w_enter_tlr) begin
                r_instruction <= OPC_IDCODE;
                r_ir_shift    <= '0;
            end
        end
    end

    // tdo is the LSB of whichever register is currently in its shift state.
    always_comb begin
        w_tdo = 1'b0;
        case (w_state)
            TAP_SHIFT_IR: w_tdo = r_ir_shift[0];
            TAP_SHIFT_DR: begin
                case (w_dr_sel)
                    DR_SEL_IDCODE:     w_tdo = r_idcode_shift[0];
                    DR_SEL_TESTVECTOR: w_tdo = r_tv_shift[0];
                    default:           w_tdo = r_bypass;
                endcase
            end
            default: ;
        endcase
    end

    assign io_jtag.tdo           = w_tdo;
    assign io_jtag.tdoEnable     = (w_state == TAP_SHIFT_IR) || (w_state == TAP_SHIFT_DR);
    assign io_jtag.tapState      = w_state;
    assign io_jtag.instruction   = r_instruction;
    assign io_jtag.testVectorOut = r_tv_out;
    assign io_jtag.updateValid   = r_update_valid;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// -----------------------------------------------------------------------------
// tb_jtag_tap_controller
// Drives tms/tdi/testVectorIn one TCK at a time, predicts every cycle's
// outputs with a bit-queue reference model, and lets a monitor compare them.
// -----------------------------------------------------------------------------
module tb_jtag_tap_controller;
    import jtag_tap_controller_pkg::*;

    localparam int          IW  = 5;
    localparam int          TVW = 8;
    localparam logic [31:0] IDC = 32'h1234_5677;
    localparam int          OW  = 4 + 3 + IW + TVW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    jtag_tap_controller_if #(.INSTR_WIDTH(IW), .TEST_VECTOR_WIDTH(TVW)) jif ();

    jtag_tap_controller #(
        .INSTR_WIDTH       (IW),
        .TEST_VECTOR_WIDTH (TVW),
        .IDCODE_VALUE      (IDC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .io_jtag (jif.slave)
    );

    // ---------------- scoreboard state ----------------
    logic [OW-1:0] exp_q[$];
    int            total = 0;
    int            bad   = 0;
    bit            tdo_log[$];
    int            uv_cnt = 0;
    logic [TVW-1:0] tv_in = '0;

    // ---------------- reference model ----------------
    JtagTapStateEnum nxt_tbl[16][2];
    JtagTapStateEnum m_state = TAP_TEST_LOGIC_RESET;
    int              m_instr = 1;
    logic [TVW-1:0]  m_tvout = '0;
    bit              m_ir[$];
    bit              m_dr[$];

    task automatic set_edge(input JtagTapStateEnum s, input JtagTapStateEnum on0,
                            input JtagTapStateEnum on1);
        nxt_tbl[int'(s)][0] = on0;
        nxt_tbl[int'(s)][1] = on1;
    endtask

    task automatic build_table();
        set_edge(TAP_TEST_LOGIC_RESET, TAP_RUN_TEST_IDLE, TAP_TEST_LOGIC_RESET);
        set_edge(TAP_RUN_TEST_IDLE,    TAP_RUN_TEST_IDLE, TAP_SELECT_DR);
        set_edge(TAP_SELECT_DR,        TAP_CAPTURE_DR,    TAP_SELECT_IR);
        set_edge(TAP_CAPTURE_DR,       TAP_SHIFT_DR,      TAP_EXIT1_DR);
        set_edge(TAP_SHIFT_DR,         TAP_SHIFT_DR,      TAP_EXIT1_DR);
        set_edge(TAP_EXIT1_DR,         TAP_PAUSE_DR,      TAP_UPDATE_DR);
        set_edge(TAP_PAUSE_DR,         TAP_PAUSE_DR,      TAP_EXIT2_DR);
        set_edge(TAP_EXIT2_DR,         TAP_SHIFT_DR,      TAP_UPDATE_DR);
        set_edge(TAP_UPDATE_DR,        TAP_RUN_TEST_IDLE, TAP_SELECT_DR);
        set_edge(TAP_SELECT_IR,        TAP_CAPTURE_IR,    TAP_TEST_LOGIC_RESET);
        set_edge(TAP_CAPTURE_IR,       TAP_SHIFT_IR,      TAP_EXIT1_IR);
        set_edge(TAP_SHIFT_IR,         TAP_SHIFT_IR,      TAP_EXIT1_IR);
        set_edge(TAP_EXIT1_IR,         TAP_PAUSE_IR,      TAP_UPDATE_IR);
        set_edge(TAP_PAUSE_IR,         TAP_PAUSE_IR,      TAP_EXIT2_IR);
        set_edge(TAP_EXIT2_IR,         TAP_SHIFT_IR,      TAP_UPDATE_IR);
        set_edge(TAP_UPDATE_IR,        TAP_RUN_TEST_IDLE, TAP_SELECT_DR);
    endtask

    function automatic int bits_to_int(input bit q[$]);
        int v = 0;
        for (int i = 0; i < q.size() && i < 32; i++) v = v | (int'(q[i]) << i);
        return v;
    endfunction

    // One TCK edge of the model; returns the expected post-edge observation.
    task automatic model_step(input logic t_tms, input logic t_tdi, input logic t_rst,
                              input logic [TVW-1:0] t_tvin, output logic [OW-1:0] obs);
        JtagTapStateEnum ns;
        bit uv = 1'b0;
        bit tdo_bit = 1'b0;
        logic [31:0] cap;
        int len;
        if (t_rst) begin
            ns = TAP_TEST_LOGIC_RESET;
            m_instr = 1;
            m_tvout = '0;
            m_ir.delete();
            m_dr.delete();
        end else begin
            ns = nxt_tbl[int'(m_state)][t_tms];
            case (m_state)
                TAP_CAPTURE_IR: begin
                    m_ir.delete();
                    for (int i = 0; i < IW; i++) m_ir.push_back(i == 0);
                end
                TAP_SHIFT_IR: begin
                    void'(m_ir.pop_front());
                    m_ir.push_back(t_tdi);
                end
                TAP_UPDATE_IR: m_instr = bits_to_int(m_ir);
                TAP_CAPTURE_DR: begin
                    if (m_instr == 1)      begin cap = IDC;            len = 32;  end
                    else if (m_instr == 2) begin cap = 32'(t_tvin);    len = TVW; end
                    else                   begin cap = 32'd0;          len = 1;   end
                    m_dr.delete();
                    for (int i = 0; i < len; i++) m_dr.push_back(cap[i]);
                end
                TAP_SHIFT_DR: begin
                    void'(m_dr.pop_front());
                    m_dr.push_back(t_tdi);
                end
                default: ;
            endcase
            if (ns == TAP_UPDATE_DR && m_instr == 2) begin
                m_tvout = TVW'(bits_to_int(m_dr));
                uv = 1'b1;
            end
            if (ns == TAP_TEST_LOGIC_RESET) begin
                m_instr = 1;
                m_ir.delete();
            end
        end
        m_state = ns;
        if (ns == TAP_SHIFT_IR && m_ir.size() > 0) tdo_bit = m_ir[0];
        if (ns == TAP_SHIFT_DR && m_dr.size() > 0) tdo_bit = m_dr[0];
        obs = {ns, tdo_bit, (ns == TAP_SHIFT_IR || ns == TAP_SHIFT_DR), uv,
               IW'(m_instr), m_tvout};
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic t_tms, input logic t_tdi, input logic t_rst);
        logic [OW-1:0] e;
        @(negedge clk);
        reset = t_rst;
        jif.tms = t_tms;
        jif.tdi = t_tdi;
        jif.testVectorIn = tv_in;
        model_step(t_tms, t_tdi, t_rst, tv_in, e);
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // From Run-Test/Idle, load an instruction and return to Run-Test/Idle.
    task automatic ir_scan(input logic [IW-1:0] val);
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        for (int i = 0; i < IW; i++) step(i == IW - 1, val[i], 0);
        step(1, 0, 0);
        step(0, 0, 0);
    endtask

    // From Run-Test/Idle, shift len bits of val (LSB first) through the DR.
    task automatic dr_scan(input int len, input logic [31:0] val);
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        for (int i = 0; i < len; i++) step(i == len - 1, val[i % 32], 0);
        step(1, 0, 0);
        step(0, 0, 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        logic [OW-1:0] act;
        logic [OW-1:0] e;
        #1;
        act = {jif.tapState, jif.tdo, jif.tdoEnable, jif.updateValid,
               jif.instruction, jif.testVectorOut};
        if (jif.tdoEnable === 1'b1) tdo_log.push_back(jif.tdo);
        if (jif.updateValid === 1'b1) uv_cnt++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL cycle_obs @%0t: got state=%0d tdo=%b en=%b uv=%b instr=%0d tvout=%h expected state=%0d tdo=%b en=%b uv=%b instr=%0d tvout=%h",
                         $time, act[OW-1 -: 4], act[OW-5], act[OW-6], act[OW-7],
                         act[TVW +: IW], act[TVW-1:0],
                         e[OW-1 -: 4], e[OW-5], e[OW-6], e[OW-7],
                         e[TVW +: IW], e[TVW-1:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        build_table();
        jif.tms = 1'b1;
        jif.tdi = 1'b0;
        jif.testVectorIn = '0;

        // Reset state
        step(1, 0, 1);
        step(0, 0, 1);
        chk("reset_state", 32'(jif.tapState), 32'(TAP_TEST_LOGIC_RESET));
        chk("reset_instr", 32'(jif.instruction), 32'd1);
        chk("reset_tvout", 32'(jif.testVectorOut), 32'd0);
        chk("reset_tdo_en", {30'd0, jif.tdoEnable, jif.updateValid}, 32'd0);
        step(0, 0, 0);

        // IDCODE scan straight after reset
        tdo_log.delete();
        dr_scan(32, 32'd0);
        chk("idcode_len", 32'(tdo_log.size()), 32'd32);
        chk("idcode_value", 32'(bits_to_int(tdo_log)), IDC);

        // IR scan selecting TESTVECTOR
        tdo_log.delete();
        ir_scan(IW'(2));
        chk("ir_capture_bits", {30'd0, tdo_log[1], tdo_log[0]}, 32'd1);
        chk("ir_instr_tv", 32'(jif.instruction), 32'd2);

        // Test-vector scan: capture 3C, shift in A5
        tdo_log.delete();
        uv_cnt = 0;
        tv_in = 8'h3C;
        dr_scan(TVW, 32'hA5);
        chk("tv_capture", 32'(bits_to_int(tdo_log)), 32'h3C);
        chk("tv_update", 32'(jif.testVectorOut), 32'hA5);
        chk("tv_uv_pulses", 32'(uv_cnt), 32'd1);

        // Five tms=1 from ShiftDR reach Test-Logic-Reset
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        chk("tms5_state", 32'(jif.tapState), 32'(TAP_TEST_LOGIC_RESET));
        chk("tms5_instr", 32'(jif.instruction), 32'd1);
        step(0, 0, 0);

        // Unknown opcode -> bypass with one-cycle delay
        ir_scan(IW'(7));
        tdo_log.delete();
        dr_scan(4, 32'b1101);
        chk("bypass_len", 32'(tdo_log.size()), 32'd4);
        chk("bypass_bits", 32'(bits_to_int(tdo_log)), 32'b1010);

        // Reset mid-way through a test-vector shift
        ir_scan(IW'(2));
        uv_cnt = 0;
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0);
        step(0, 1, 1);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("midrst_uv", 32'(uv_cnt), 32'd0);
        chk("midrst_tvout", 32'(jif.testVectorOut), 32'd0);
        chk("midrst_state", 32'(jif.tapState), 32'(TAP_TEST_LOGIC_RESET));
        chk("midrst_instr", 32'(jif.instruction), 32'd1);
        step(0, 0, 0);

        // Randomised structured scans
        for (int n = 0; n < 40; n++) begin
            tv_in = TVW'($urandom);
            ir_scan(IW'($urandom_range(0, 7)));
            dr_scan($urandom_range(1, 40), $urandom);
        end

        // Random walk on tms/tdi with occasional reset
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 15) == 0) tv_in = TVW'($urandom);
            step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 199) == 0);
        end

        // Drain
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jtag_tap_controller.md
# jtag_tap_controller

Parametrised IEEE 1149.1-style TAP controller for the JTAG AVIP slave side, with a configurable instruction width, test-vector width and IDCODE. It runs the 16-state TAP FSM from `tms` and handles three data registers:

- the 1-bit bypass register,
- a 32-bit IDCODE register,
- a test-vector register with parallel capture and update ports.

It sits between the JTAG pin interface and the DUT-side test logic, and is the reference model the slave driver/monitor are checked against.

## Interface
- `INSTR_WIDTH`, 5 — instruction register width; legal values 3, 4, 5.
- `TEST_VECTOR_WIDTH`, 32 — test-vector register width; legal values 8, 16, 24, 32.
- `IDCODE_VALUE`, 32'h1234_5677 — IDCODE captured on IDCODE scans; bit 0 must be 1.
- `clk`  in  1 — TCK; the only clock; all state updates on the rising edge.
- `reset`  in  1 — synchronous, active-high reset.
- `tms`  in  1 — test mode select, sampled every rising edge.
- `tdi`  in  1 — serial data in, sampled on rising edges in Shift-IR/Shift-DR.
- `tdo`  out  1 — serial data out.
- `tdoEnable`  out  1 — high while in Shift-IR or Shift-DR.
- `tapState`  out  4 — current FSM state (`JtagTapStateEnum` encoding).
- `instruction`  out  INSTR_WIDTH — active instruction register.
- `testVectorIn`  in  TEST_VECTOR_WIDTH — parallel value loaded in Capture-DR when TESTVECTOR is selected.
- `testVectorOut`  out  TEST_VECTOR_WIDTH — parallel value written in Update-DR when TESTVECTOR is selected.
- `updateValid`  out  1 — one-cycle pulse when `testVectorOut` is written.

## Operation

**Opcodes**
- BYPASS = 0, IDCODE = 1, TESTVECTOR = 2, zero-extended to INSTR_WIDTH.
- Any other opcode selects the bypass register.

**FSM**
- Standard 16 states: TestLogicReset, RunTestIdle, SelectDR, CaptureDR, ShiftDR, Exit1DR, PauseDR, Exit2DR, UpdateDR, and the IR equivalents.
- Transitions follow IEEE 1149.1 on `tms`.
- Five consecutive `tms`=1 cycles reach TestLogicReset from any state.

**Entering TestLogicReset** (by `reset` or by `tms`)
- `instruction` <= IDCODE.
- The IR shift register is cleared.

**IR path**
- CaptureIR: IR shift register <= {zeros, 2'b01}.
- ShiftIR: shift right; `tdi` enters the MSB.
- UpdateIR: `instruction` <= IR shift register.

**DR path** (data register chosen by `instruction`)
- CaptureDR:
  - BYPASS loads 0.
  - IDCODE loads IDCODE_VALUE.
  - TESTVECTOR loads `testVectorIn`.
- ShiftDR: the selected register shifts right, `tdi` into its MSB; bypass is a single flop.
- UpdateDR with TESTVECTOR selected: `testVectorOut` <= shift register and `updateValid` = 1 for that cycle.
- UpdateDR with any other instruction: no parallel effect.

**Serial output**
- `tdo` = LSB of the active shift register (IR in Shift-IR, selected DR in Shift-DR), decoded combinationally from registered state.
- `tdo` = 0 in all other states.

**Pause states**
- PauseDR/PauseIR hold shift register contents unchanged.

## Timing

**Reset values**
- `tapState` = TestLogicReset.
- `instruction` = IDCODE.
- `testVectorOut` = 0.
- `updateValid` = 0, `tdo` = 0, `tdoEnable` = 0.
- All shift registers = 0.

**State and shift timing**
- State changes one edge after `tms` is sampled.
- `tdoEnable` rises in the cycle the FSM is in a Shift state.
- An N-bit register needs N rising edges in its Shift state. The last bit is shifted on the edge that leaves to Exit1 (`tms`=1).
- The first `tdo` bit is the captured LSB, visible in the first Shift cycle.
- Bypass: `tdi` appears on `tdo` exactly one shift cycle later.

**Update timing**
- `updateValid` is high only in the UpdateDR cycle.
- `testVectorOut` is valid from that cycle and held until the next TESTVECTOR update or reset.

**Simultaneous events and reset**
- `reset` overrides `tms`.
- `reset` mid-shift discards the partial shift: no update occurs and `instruction` returns to IDCODE on the next cycle.

## Structure
- `JtagGlobalPkg` gains:
  - `JtagTapStateEnum` (4-bit);
  - an extended `JtagInstructionOpcodeEnum` (BYPASS, IDCODE, TESTVECTOR);
  - a default IDCODE constant.
- The existing width enums bound the parameter values.
- Sub-module `jtag_tap_fsm`: the state register plus next-state logic, outputting `tapState`.
- The top level holds the IR, the DRs and the output mux.

## Test plan
- Reset, then drive `tms` = 1,1,1,1,1 from ShiftDR → `tapState` = TestLogicReset on the 5th edge and `instruction` = 1.
- After reset, perform an IDCODE DR scan of 32 bits with `tdi`=0 → `tdo` shows 32'h1234_5677 LSB first.
- IR scan writing TESTVECTOR with INSTR_WIDTH=5 → the first two bits on `tdo` are 1,0 (capture 01) and `instruction` = 5'd2 after UpdateIR.
- TESTVECTOR scan with TEST_VECTOR_WIDTH=8, `testVectorIn`=8'h3C, shifting in 8'hA5 → `tdo` gives 3C LSB first, `testVectorOut`=8'hA5, and `updateValid` pulses once.
- Unknown opcode 5'd7 followed by a 4-cycle DR shift of 1,0,1,1 → `tdo` = 0,1,0,1 (bypass, one-cycle delay).
- Assert `reset` after 4 of 8 TESTVECTOR shift bits → no `updateValid` pulse, `testVectorOut` = 0, and the FSM is in TestLogicReset.
